wall_probe_scheduler: RTL and testbench

Time-multiplexes a single one-read-port maze wall lookup among several moving sprites (Pac-Man plus ghosts). For the granted requester it issues four neighbour probes: up, down, left, right, each offset by that sprite's step size. It collects the registered wall bits and returns them as one 4-bit flag word. It sits between the per-sprite motion blocks and the shared synchronous maze wall memory. It replaces per-sprite combinational wall lookups.

---
 rtl/wall_probe_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_wall_probe_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_probe_scheduler.sv
// Round-robin scheduler sharing one registered-read maze wall lookup among sprites.
// Each grant issues Up/Down/Left/Right probes and returns the four wall bits as one flag word.
module wall_probe_scheduler #(
  parameter int NUM_REQ = 5,
  parameter int COORD_W = 10
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COORD_W-1:0] obj_x,
  input  logic [NUM_REQ*COORD_W-1:0] obj_y,
  input  logic [NUM_REQ*COORD_W-1:0] obj_s,
  output logic [NUM_REQ-1:0]         grant,
  output logic [COORD_W-1:0]         probe_x,
  output logic [COORD_W-1:0]         probe_y,
  output logic                       probe_valid,
  input  logic                       wall_bit,
  output logic [NUM_REQ-1:0]         done,
  output logic [3:0]                 walls,
  output logic                       busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stateT;

  stateT              stateReg, stateNext;
  logic [1:0]         dirReg, dirNext;
  logic [IDX_W-1:0]   idxReg, idxNext;
  logic [IDX_W-1:0]   lastGrantReg, lastGrantNext;
  logic [COORD_W-1:0] xReg, xNext, yReg, yNext, sReg, sNext;
  logic [NUM_REQ-1:0] grantReg, grantNext;
  logic [NUM_REQ-1:0] doneReg, doneNext;
  logic [COORD_W-1:0] probeXReg, probeXNext, probeYReg, probeYNext;
  logic               probeValidReg, probeValidNext;
  logic [3:0]         flagsReg, flagsNext;
  logic [3:0]         wallsReg, wallsNext;
  logic               capValidReg, capValidNext;
  logic [1:0]         capDirReg, capDirNext;

  logic [COORD_W-1:0] objX [NUM_REQ];
  logic [COORD_W-1:0] objY [NUM_REQ];
  logic [COORD_W-1:0] objS [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
      assign objX[gi] = obj_x[gi*COORD_W +: COORD_W];
      assign objY[gi] = obj_y[gi*COORD_W +: COORD_W];
      assign objS[gi] = obj_s[gi*COORD_W +: COORD_W];
    end
  endgenerate

  // Round-robin search starting just after the last served requester.
  logic             winFound;
  logic [IDX_W-1:0] winIdx;
  logic [IDX_W-1:0] candIdx;
  int               cand;

  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = 0;
    candIdx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand    = (int'(lastGrantReg) + k) % NUM_REQ;
      candIdx = IDX_W'(cand);
      if (!winFound && req[candIdx]) begin
        winFound = 1'b1;
        winIdx   = candIdx;
      end
    end
  end

  always_comb begin
    stateNext      = stateReg;
    dirNext        = dirReg;
    idxNext        = idxReg;
    lastGrantNext  = lastGrantReg;
    xNext          = xReg;
    yNext          = yReg;
    sNext          = sReg;
    grantNext      = grantReg;
    doneNext       = '0;
    probeXNext     = probeXReg;
    probeYNext     = probeYReg;
    probeValidNext = 1'b0;
    wallsNext      = wallsReg;
    capValidNext   = probeValidReg;
    capDirNext     = dirReg;
    flagsNext      = flagsReg;

    // Wall bit answers the probe of the previous cycle; Up lands in bit 3, Right in bit 0.
    if (capValidReg) begin
      flagsNext[~capDirReg] = wall_bit;
    end

    case (stateReg)
      IDLE: begin
        if (winFound) begin
          idxNext        = winIdx;
          grantNext      = NUM_REQ'(1) << winIdx;
          xNext          = objX[winIdx];
          yNext          = objY[winIdx];
          sNext          = objS[winIdx];
          dirNext        = 2'd0;
          // Up probe is launched straight from the inputs so it is on the bus in the first service cycle.
          probeXNext     = objX[winIdx];
          probeYNext     = objY[winIdx] - objS[winIdx];
          probeValidNext = 1'b1;
          stateNext      = ISSUE;
        end
      end
      ISSUE: begin
        dirNext        = dirReg + 2'd1;
        probeValidNext = 1'b1;
        case (dirReg)
          2'd0: begin
            probeXNext = xReg;
            probeYNext = yReg + sReg;
          end
          2'd1: begin
            probeXNext = xReg - sReg;
            probeYNext = yReg;
          end
          2'd2: begin
            probeXNext = xReg + sReg;
            probeYNext = yReg;
          end
          default: begin
            probeValidNext = 1'b0;
            stateNext      = DRAIN;
          end
        endcase
      end
      DRAIN: begin
        // Right bit arrives now; merge it directly so walls is valid alongside done.
        doneNext  = grantReg;
        wallsNext = {flagsReg[3:1], wall_bit};
        stateNext = DONE;
      end
      DONE: begin
        grantNext     = '0;
        lastGrantNext = idxReg;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateReg      <= IDLE;
      dirReg        <= '0;
      idxReg        <= '0;
      lastGrantReg  <= IDX_W'(NUM_REQ - 1);
      xReg          <= '0;
      yReg          <= '0;
      sReg          <= '0;
      grantReg      <= '0;
      doneReg       <= '0;
      probeXReg     <= '0;
      probeYReg     <= '0;
      probeValidReg <= 1'b0;
      flagsReg      <= '0;
      wallsReg      <= '0;
      capValidReg   <= 1'b0;
      capDirReg     <= '0;
    end else begin
      stateReg      <= stateNext;
      dirReg        <= dirNext;
      idxReg        <= idxNext;
      lastGrantReg  <= lastGrantNext;
      xReg          <= xNext;
      yReg          <= yNext;
      sReg          <= sNext;
      grantReg      <= grantNext;
      doneReg       <= doneNext;
      probeXReg     <= probeXNext;
      probeYReg     <= probeYNext;
      probeValidReg <= probeValidNext;
      flagsReg      <= flagsNext;
      wallsReg      <= wallsNext;
      capValidReg   <= capValidNext;
      capDirReg     <= capDirNext;
    end
  end

  assign grant       = grantReg;
  assign done        = doneReg;
  assign probe_x     = probeXReg;
  assign probe_y     = probeYReg;
  assign probe_valid = probeValidReg;
  assign walls       = wallsReg;
  assign busy        = (stateReg != IDLE);

endmodule

// File: tb/tb_wall_probe_scheduler.sv
// Scoreboard bench: a transaction-level model predicts grants, probe addresses and wall words,
// while the bench itself plays the role of the synchronous wall memory.
module tb_wall_probe_scheduler;
  localparam int NUM_REQ = 5;
  localparam int COORD_W = 10;
  localparam int MASK    = (1 << COORD_W) - 1;

  logic                       Clk = 1'b0;
  logic                       Reset = 1'b1;
  logic [NUM_REQ-1:0]         req = '0;
  logic [NUM_REQ*COORD_W-1:0] obj_x = '0, obj_y = '0, obj_s = '0;
  logic                       wall_bit = 1'b0;
  logic [NUM_REQ-1:0]         grant, done;
  logic [COORD_W-1:0]         probe_x, probe_y;
  logic                       probe_valid, busy;
  logic [3:0]                 walls;

  wall_probe_scheduler #(.NUM_REQ(NUM_REQ), .COORD_W(COORD_W)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .obj_x(obj_x), .obj_y(obj_y), .obj_s(obj_s),
    .grant(grant), .probe_x(probe_x), .probe_y(probe_y), .probe_valid(probe_valid),
    .wall_bit(wall_bit), .done(done), .walls(walls), .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {int idx; int x; int y; int due;} probeT;
  typedef struct {int idx; int w; int due;} svcT;
  probeT probeQ[$];
  svcT   svcQ[$];
  bit    wallMem[int];
  int    seed;
  int    cyc = 0, vecs = 0, errs = 0;
  int    mLast = NUM_REQ - 1, mFree = 0, mCur = -1;

  function automatic int memBit(int x, int y);
    int key;
    key = (x << COORD_W) | y;
    if (wallMem.exists(key)) return int'(wallMem[key]);
    return ((((x * 37) ^ (y * 11) ^ seed) >> 2) & 1);
  endfunction

  function automatic int field(logic [NUM_REQ*COORD_W-1:0] v, int i);
    return int'(v[i*COORD_W +: COORD_W]);
  endfunction

  task automatic check(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Service takes 7 cycles; the winner is the first requester after the last served one.
  task automatic modelEdge();
    int w, x, y, s, wv;
    int px[4];
    int py[4];
    if (Reset) return;
    if (cyc >= mFree && req != '0) begin
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (mLast + k) % NUM_REQ;
        if (w < 0 && req[c]) w = c;
      end
      x = field(obj_x, w);
      y = field(obj_y, w);
      s = field(obj_s, w);
      px[0] = x;              py[0] = (y - s) & MASK;
      px[1] = x;              py[1] = (y + s) & MASK;
      px[2] = (x - s) & MASK; py[2] = y;
      px[3] = (x + s) & MASK; py[3] = y;
      wv = 0;
      for (int d = 0; d < 4; d++) begin
        probeQ.push_back('{w, px[d], py[d], cyc + d});
        wv |= memBit(px[d], py[d]) << (3 - d);
      end
      svcQ.push_back('{w, wv, cyc + 5});
      mLast = w;
      mCur  = w;
      mFree = cyc + 7;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    cyc++;
    modelEdge();
    #1;
  endtask

  task automatic checkIdleOutputs(string tag);
    check({tag, "_grant"}, int'(grant), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_walls"}, int'(walls), 0);
    check({tag, "_probe_valid"}, int'(probe_valid), 0);
    check({tag, "_probe_x"}, int'(probe_x), 0);
    check({tag, "_probe_y"}, int'(probe_y), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic doReset();
    Reset = 1'b1;
    probeQ.delete();
    svcQ.delete();
    mLast = NUM_REQ - 1;
    mFree = 0;
    mCur  = -1;
    #1;
    checkIdleOutputs("reset");
    step();
    Reset = 1'b0;
  endtask

  task automatic setObj(int i, int x, int y, int s);
    obj_x[i*COORD_W +: COORD_W] = COORD_W'(x);
    obj_y[i*COORD_W +: COORD_W] = COORD_W'(y);
    obj_s[i*COORD_W +: COORD_W] = COORD_W'(s);
  endtask

  task automatic randObj();
    for (int i = 0; i < NUM_REQ; i++)
      setObj(i, int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), int'($urandom_range(0, 63)));
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (probeQ.size() > 0 || svcQ.size() > 0); n++) step();
  endtask

  // Wall memory: answers one cycle after each probe, noise otherwise.
  logic                pvS;
  logic [COORD_W-1:0] pxS, pyS;
  always @(negedge Clk) begin
    pvS = probe_valid;
    pxS = probe_x;
    pyS = probe_y;
  end
  always @(posedge Clk) begin
    #1;
    if (pvS) wall_bit = (memBit(int'(pxS), int'(pyS)) != 0);
    else     wall_bit = ($urandom_range(0, 1) == 1);
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      while (probeQ.size() > 0 && probeQ[0].due < cyc) begin
        check("probe_missing", 0, 1);
        void'(probeQ.pop_front());
      end
      while (svcQ.size() > 0 && svcQ[0].due < cyc) begin
        check("done_missing", 0, 1);
        void'(svcQ.pop_front());
      end
      if (probe_valid) begin
        if (probeQ.size() == 0 || probeQ[0].due != cyc) begin
          check("probe_unexpected", 1, 0);
        end else begin
          check("probe_x", int'(probe_x), probeQ[0].x);
          check("probe_y", int'(probe_y), probeQ[0].y);
          check("probe_grant", int'(grant), 1 << probeQ[0].idx);
          check("probe_busy", int'(busy), 1);
          $display("probe cyc=%0d req=%0d (%0d,%0d)", cyc, probeQ[0].idx, probe_x, probe_y);
          void'(probeQ.pop_front());
        end
      end
      if (done != '0) begin
        if (svcQ.size() == 0 || svcQ[0].due != cyc) begin
          check("done_unexpected", int'(done), 0);
        end else begin
          check("done_onehot", int'(done), 1 << svcQ[0].idx);
          check("walls", int'(walls), svcQ[0].w);
          $display("done  cyc=%0d req=%0d walls=%b", cyc, svcQ[0].idx, walls);
          void'(svcQ.pop_front());
        end
      end
    end
  end

  initial begin
    seed = int'($urandom);
    Reset = 1'b1;
    repeat (3) step();
    checkIdleOutputs("por");
    Reset = 1'b0;
    step();

    // Single request with fixed wall contents 1,0,0,1.
    wallMem[(100 << COORD_W) | 72] = 1'b1;
    wallMem[(100 << COORD_W) | 88] = 1'b0;
    wallMem[(92 << COORD_W) | 80]  = 1'b0;
    wallMem[(108 << COORD_W) | 80] = 1'b1;
    setObj(0, 100, 80, 8);
    req = 5'b00001;
    step();
    check("single_first_y", int'(probe_y), 72);
    repeat (5) step();
    check("single_done", int'(done), 1);
    check("single_walls", int'(walls), 4'b1001);
    req = '0;
    repeat (2) step();

    // Wrap-around arithmetic.
    setObj(1, 4, 2, 8);
    req = 5'b00010;
    step();
    check("wrap_up_y", int'(probe_y), 1018);
    repeat (2) step();
    check("wrap_left_x", int'(probe_x), 1020);
    repeat (3) step();
    req = '0;
    drain();

    // Round robin from reset with every requester pending.
    doReset();
    randObj();
    req = '1;
    repeat (44) step();
    req = '0;
    drain();

    // Reset while the Left probe is out; then 0 must beat 3.
    req = 5'b00100;
    repeat (3) step();
    check("rst_mid_probe_valid", int'(probe_valid), 1);
    req = 5'b01001;
    doReset();
    step();
    check("post_rst_grant", int'(grant), 1);
    repeat (12) step();
    req = '0;
    drain();

    // Coordinates change and req drops during service.
    req = 5'b00100;
    step();
    step();
    randObj();
    step();
    req = '0;
    repeat (6) step();
    drain();

    // Back-to-back: requester 1 alone, then 4 joins.
    req = 5'b00010;
    repeat (10) step();
    req = 5'b10010;
    repeat (20) step();
    req = '0;
    drain();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      randObj();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
        end else if (i == mCur && cyc < mFree && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 499) == 0) doReset();
      else step();
    end
    req = '0;
    drain();
    check("left_probes", probeQ.size(), 0);
    check("left_services", svcQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
